bist_fail_logger: RTL and testbench

//  Receive-side companion to the BIST engine. Captures every fail pulse with its failing SRAM

---
 rtl/bist_fail_logger.sv | 172 +++++++++++++++++
 tb/tb_bist_fail_logger.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_fail_logger.sv
// Receive-side BIST fail logger: captures fail address/word into a FWFT FIFO,
// keeps a saturating fail count and a sticky overflow flag, drained by a host.
module bist_fail_logger #(
    parameter int ADDR_WIDTH = 8,
    parameter int WORD_WIDTH = 4,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  bist_done,
    input  logic                  fail,
    input  logic [ADDR_WIDTH-1:0] fail_addr,
    input  logic [WORD_WIDTH-1:0] fail_data,
    input  logic                  log_ready,
    output logic                  log_valid,
    output logic [ADDR_WIDTH-1:0] log_addr,
    output logic [WORD_WIDTH-1:0] log_data,
    output logic [CNT_WIDTH-1:0]  fail_count,
    output logic                  overflow,
    output logic                  busy,
    output logic                  done
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int ENT_W = ADDR_WIDTH + WORD_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      w_wr_ptr_nxt;
    logic [PTR_W-1:0]      w_rd_ptr_nxt;
    logic [ENT_W-1:0]      r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_log_addr;
    logic [WORD_WIDTH-1:0] r_log_data;
    logic [ENT_W-1:0]      w_head_nxt;
    logic [ENT_W-1:0]      w_fail_entry;
    logic [CNT_WIDTH-1:0]  r_fail_count;
    logic                  r_overflow;
    logic                  r_done;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_capture;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_drop;
    logic                  w_drain_end;

    assign w_fail_entry = {fail_addr, fail_data};

    // Pointers carry one extra MSB so that full and empty are distinguishable.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) &&
                     (r_wr_ptr[PTR_W-2:0] == r_rd_ptr[PTR_W-2:0]);

    // start wins over everything; a fail coincident with start is discarded.
    assign w_capture = fail && (r_state == S_CAPTURE) && !start;
    assign w_pop     = !w_empty && log_ready && !start;
    assign w_push    = w_capture && (!w_full || w_pop);
    assign w_drop    = w_capture && w_full && !w_pop;

    assign w_wr_ptr_nxt = start ? '0 : (w_push ? r_wr_ptr + PTR_W'(1) : r_wr_ptr);
    assign w_rd_ptr_nxt = start ? '0 : (w_pop  ? r_rd_ptr + PTR_W'(1) : r_rd_ptr);

    assign w_drain_end = (r_state == S_DRAIN) && w_empty && !start;

    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = S_CAPTURE;
        end else begin
            case (r_state)
                S_IDLE:    w_state_nxt = S_IDLE;
                S_CAPTURE: if (bist_done) w_state_nxt = S_DRAIN;
                S_DRAIN:   if (w_empty) w_state_nxt = S_IDLE;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
        end
    end

    // Storage array is data only; validity is carried entirely by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[IDX_W-1:0]] <= w_fail_entry;
        end
    end

    // Registered head for first-word-fall-through. When the next head slot is
    // the one being written this cycle, forward the incoming entry directly.
    always_comb begin
        w_head_nxt = {r_log_addr, r_log_data};
        if (w_wr_ptr_nxt != w_rd_ptr_nxt) begin
            if (w_rd_ptr_nxt == r_wr_ptr) begin
                w_head_nxt = w_fail_entry;
            end else begin
                w_head_nxt = r_mem[w_rd_ptr_nxt[IDX_W-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_log_addr <= '0;
            r_log_data <= '0;
        end else begin
            r_log_addr <= w_head_nxt[ENT_W-1:WORD_WIDTH];
            r_log_data <= w_head_nxt[WORD_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fail_count <= '0;
            r_overflow   <= 1'b0;
            r_done       <= 1'b0;
        end else if (start) begin
            r_fail_count <= '0;
            r_overflow   <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            if (w_capture) begin
                r_fail_count <= sat_inc(r_fail_count);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_drain_end) begin
                r_done <= 1'b1;
            end
        end
    end

    assign log_valid  = !w_empty;
    assign log_addr   = r_log_addr;
    assign log_data   = r_log_data;
    assign fail_count = r_fail_count;
    assign overflow   = r_overflow;
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;

endmodule

// File: tb/tb_bist_fail_logger.sv
// Directed bench for bist_fail_logger: capture, FIFO ordering, overflow,
// full push+pop, ignored fails, counter saturation and mid-run reset.
module tb_bist_fail_logger;

    logic       clk = 1'b0;
    logic       rst, start, bist_done, fail, log_ready;
    logic [7:0] fail_addr;
    logic [3:0] fail_data;
    logic       log_valid;
    logic [7:0] log_addr;
    logic [3:0] log_data;
    logic [8:0] fail_count;
    logic       overflow, busy, done;

    int n_vec = 0;
    int n_err = 0;

    bist_fail_logger #(.ADDR_WIDTH(8), .WORD_WIDTH(4), .DEPTH(8), .CNT_WIDTH(9)) dut (
        .clk(clk), .rst(rst), .start(start), .bist_done(bist_done), .fail(fail),
        .fail_addr(fail_addr), .fail_data(fail_data), .log_ready(log_ready),
        .log_valid(log_valid), .log_addr(log_addr), .log_data(log_data),
        .fail_count(fail_count), .overflow(overflow), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] dat_of(input logic [7:0] a);
        return a[3:0] ^ 4'hA;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_done: done=%b busy=%b, required done=1 busy=0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; bist_done = 0; fail = 0; log_ready = 0;
        fail_addr = 0; fail_data = 0;
        tick(); tick();
        rst = 1'b0;
        n_vec++;
        if ({log_valid, log_addr, log_data, fail_count, overflow, busy, done} !== 26'd0) begin
            n_err++;
            $display("FAIL reset: valid=%b addr=%h data=%h cnt=%0d ovf=%b busy=%b done=%b, required all 0",
                     log_valid, log_addr, log_data, fail_count, overflow, busy, done);
        end
    endtask

    task automatic test_single();
        pulse_start();
        n_vec++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL single_busy: busy=%b done=%b, required 1/0", busy, done);
        end
        fail = 1; fail_addr = 8'h12; fail_data = 4'h5; log_ready = 1;
        tick();
        fail = 0;
        n_vec++;
        if (log_valid !== 1'b1 || log_addr !== 8'h12 || log_data !== 4'h5 || fail_count !== 9'd1) begin
            n_err++;
            $display("FAIL single_entry: valid=%b addr=%h data=%h cnt=%0d, required 1 12 5 1",
                     log_valid, log_addr, log_data, fail_count);
        end
        bist_done = 1;
        tick();
        bist_done = 0;
        n_vec++;
        if (log_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_pop: valid=%b, required 0", log_valid);
        end
        wait_done("single");
        log_ready = 0;
    endtask

    task automatic fill(input int n);
        log_ready = 0;
        for (int i = 0; i < n; i++) begin
            fail = 1; fail_addr = 8'(i); fail_data = dat_of(8'(i));
            tick();
        end
        fail = 0;
    endtask

    task automatic drain_check(input string name, input int first, input int n);
        log_ready = 1;
        for (int i = 0; i < n; i++) begin
            n_vec++;
            if (log_valid !== 1'b1 || log_addr !== 8'(first + i) || log_data !== dat_of(8'(first + i))) begin
                n_err++;
                $display("FAIL %s_entry%0d: valid=%b addr=%h data=%h, required 1 %h %h", name, i,
                         log_valid, log_addr, log_data, 8'(first + i), dat_of(8'(first + i)));
            end
            tick();
        end
        n_vec++;
        if (log_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s_empty: valid=%b, required 0", name, log_valid);
        end
        log_ready = 0;
    endtask

    task automatic end_run();
        bist_done = 1;
        tick();
        bist_done = 0;
    endtask

    task automatic test_fill();
        pulse_start();
        fill(8);
        n_vec++;
        if (fail_count !== 9'd8 || overflow !== 1'b0 || log_valid !== 1'b1) begin
            n_err++;
            $display("FAIL fill_status: cnt=%0d ovf=%b valid=%b, required 8 0 1", fail_count, overflow, log_valid);
        end
        end_run();
        drain_check("fill", 0, 8);
        wait_done("fill");
    endtask

    task automatic test_overflow();
        pulse_start();
        n_vec++;
        if (done !== 1'b0 || fail_count !== 9'd0) begin
            n_err++;
            $display("FAIL ovf_clear: done=%b cnt=%0d, required 0 0", done, fail_count);
        end
        fill(10);
        n_vec++;
        if (fail_count !== 9'd10 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_status: cnt=%0d ovf=%b, required 10 1", fail_count, overflow);
        end
        end_run();
        drain_check("ovf", 0, 8);
        wait_done("ovf");
    endtask

    task automatic test_full_pushpop();
        pulse_start();
        n_vec++;
        if (overflow !== 1'b0) begin
            n_err++;
            $display("FAIL fullpp_clear: ovf=%b, required 0", overflow);
        end
        fill(7);
        fail = 1; fail_addr = 8'h07; fail_data = dat_of(8'h07);
        tick();
        fail = 1; fail_addr = 8'h08; fail_data = dat_of(8'h08); log_ready = 1;
        tick();
        fail = 0; log_ready = 0;
        n_vec++;
        if (overflow !== 1'b0 || fail_count !== 9'd9 || log_valid !== 1'b1 || log_addr !== 8'h01) begin
            n_err++;
            $display("FAIL fullpp_status: ovf=%b cnt=%0d valid=%b head=%h, required 0 9 1 01",
                     overflow, fail_count, log_valid, log_addr);
        end
        end_run();
        drain_check("fullpp", 1, 8);
        wait_done("fullpp");
    endtask

    task automatic test_ignored();
        fail = 1; fail_addr = 8'h33; fail_data = 4'h3;
        tick(); tick();
        fail = 0;
        n_vec++;
        if (fail_count !== 9'd9 || log_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ign_idle: cnt=%0d valid=%b, required 9 0", fail_count, log_valid);
        end
        start = 1; fail = 1;
        tick();
        start = 0; fail = 0;
        n_vec++;
        if (fail_count !== 9'd0 || log_valid !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL ign_start: cnt=%0d valid=%b busy=%b, required 0 0 1", fail_count, log_valid, busy);
        end
        fail = 1; fail_addr = 8'h44; fail_data = dat_of(8'h44); bist_done = 1;
        tick();
        bist_done = 0; fail_addr = 8'h55;
        tick(); tick();
        fail = 0;
        n_vec++;
        if (fail_count !== 9'd1 || log_addr !== 8'h44 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL ign_drain: cnt=%0d head=%h busy=%b, required 1 44 1", fail_count, log_addr, busy);
        end
        drain_check("ign", 8'h44, 1);
        wait_done("ign");
    endtask

    task automatic test_saturate();
        pulse_start();
        log_ready = 1;
        for (int i = 0; i < 600; i++) begin
            fail = 1; fail_addr = 8'(i); fail_data = dat_of(8'(i));
            tick();
        end
        n_vec++;
        if (fail_count !== 9'd511 || overflow !== 1'b0 || log_valid !== 1'b1) begin
            n_err++;
            $display("FAIL sat_count: cnt=%0d ovf=%b valid=%b, required 511 0 1", fail_count, overflow, log_valid);
        end
        n_vec++;
        if (log_addr !== 8'(599) || log_data !== dat_of(8'(599))) begin
            n_err++;
            $display("FAIL sat_head: addr=%h data=%h, required %h %h", log_addr, log_data, 8'(599), dat_of(8'(599)));
        end
        rst = 1;
        tick();
        rst = 0; fail = 0; log_ready = 0;
        n_vec++;
        if ({log_valid, log_addr, log_data, fail_count, overflow, busy, done} !== 26'd0) begin
            n_err++;
            $display("FAIL midrst: valid=%b addr=%h data=%h cnt=%0d ovf=%b busy=%b done=%b, required all 0",
                     log_valid, log_addr, log_data, fail_count, overflow, busy, done);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_overflow();
        test_full_pushpop();
        test_ignored();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
